// File: rtl/scan_drv_pkg.sv
// scan_drv_pkg: shared FSM states, op-bit positions and timing helpers for scan_chain_driver
package scan_drv_pkg;
  typedef enum logic [3:0] {
    IDLE, CAP_SU, CAP_C1, CAP_G1, CAP_C2, CAP_G2,
    SH_SU, SH_C1, SH_G1, SH_C2, SH_G2, UPD, UPD_G, DONE
  } state_t;
  localparam int OP_CAPTURE = 0;
  localparam int OP_UPDATE  = 1;
  localparam int CNT_W      = 16;
  function automatic int cycles_per_bit(input int s, input int pw, input int gap);
    return s + 2 * pw + 2 * gap;
  endfunction
endpackage

// File: rtl/scan_chain_driver_timer.sv
// scan_phase_timer: down-counter loaded with a phase length; expire marks the last cycle of the phase
module scan_phase_timer
  import scan_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= len - 1'b1;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = cnt == '0;
endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: two-phase scan chain master (capture, N-bit exchange shift, update).
// Define SCAN_OUT_SYNC_EN to put a 2-flop synchronizer on scan_out (setup phase becomes 3 cycles).
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int NUM_SCAN_BITS = 395,
  parameter int PW            = 2,
  parameter int GAP           = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [NUM_SCAN_BITS-1:0] wr_data,
  output logic [NUM_SCAN_BITS-1:0] rd_data,
  output logic                     done,
  output logic                     busy,
  output logic                     clk1,
  output logic                     clk2,
  output logic                     scan_in,
  output logic                     update,
  output logic                     capture,
  input  logic                     scan_out
);
  localparam int N = NUM_SCAN_BITS;
`ifdef SCAN_OUT_SYNC_EN
  localparam int S = 3;
  logic [1:0] sync;
  logic       so;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], scan_out};
  assign so = sync[1];
`else
  localparam int S = 1;
  logic so;
  assign so = scan_out;
`endif
  state_t           state, state_d;
  logic [1:0]       op_q;
  logic [N-1:0]     wr_sr, wr_nx, rd_sr;
  logic [8:0]       bit_q;
  logic [CNT_W-1:0] len;
  logic             expire, accept, bit_end, shift_d;
  assign accept  = cmd_valid && cmd_ready;
  assign bit_end = state == SH_G2 && expire;
  assign busy    = ~cmd_ready;
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = accept ? (cmd_op[OP_CAPTURE] ? CAP_SU : SH_SU) : IDLE;
    else if (expire)
      case (state)
        CAP_SU:  state_d = CAP_C1;
        CAP_C1:  state_d = CAP_G1;
        CAP_G1:  state_d = CAP_C2;
        CAP_C2:  state_d = CAP_G2;
        CAP_G2:  state_d = SH_SU;
        SH_SU:   state_d = SH_C1;
        SH_C1:   state_d = SH_G1;
        SH_G1:   state_d = SH_C2;
        SH_C2:   state_d = SH_G2;
        SH_G2:   state_d = bit_q != '0 ? SH_SU : op_q[OP_UPDATE] ? UPD : DONE;
        UPD:     state_d = UPD_G;
        UPD_G:   state_d = DONE;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    len = state_d inside {CAP_C1, CAP_C2, SH_C1, SH_C2, UPD} ? CNT_W'(PW) :
          state_d inside {CAP_G1, CAP_G2, SH_G1, SH_G2, UPD_G} ? CNT_W'(GAP) :
          state_d == SH_SU ? CNT_W'(S) : CNT_W'(1);
    wr_nx   = accept ? wr_data : bit_end ? {wr_sr[N-2:0], 1'b0} : wr_sr;
    shift_d = state_d inside {SH_SU, SH_C1, SH_G1, SH_C2, SH_G2};
  end
  scan_phase_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_d != state),
    .len    (len),
    .expire (expire)
  );
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      bit_q     <= '0;
      rd_data   <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      clk1      <= 1'b0;
      clk2      <= 1'b0;
      scan_in   <= 1'b0;
      update    <= 1'b0;
      capture   <= 1'b0;
    end else begin
      state <= state_d;
      wr_sr <= wr_nx;
      if (accept) begin
        op_q  <= cmd_op;
        bit_q <= 9'(N - 1);
      end else if (bit_end) bit_q <= bit_q - 1'b1;
      if (state == SH_SU && expire) rd_sr <= {rd_sr[N-2:0], so};
      if (state_d == DONE) rd_data <= rd_sr;
      cmd_ready <= state_d == IDLE;
      done      <= state_d == DONE;
      clk1      <= state_d inside {CAP_C1, SH_C1};
      clk2      <= state_d inside {CAP_C2, SH_C2};
      update    <= state_d == UPD;
      capture   <= state_d inside {CAP_SU, CAP_C1, CAP_G1, CAP_C2, CAP_G2};
      scan_in   <= shift_d & wr_nx[N-1];
    end
endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: drives scan_chain_driver against a behavioural two-phase scan chain and command model
module tb_scan_chain_driver;
  localparam int N   = 8;
  localparam int PW  = 1;
  localparam int GAP = 1;
`ifdef SCAN_OUT_SYNC_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [N-1:0] wr_data = '0;
  logic         cmd_ready, done, busy, clk1, clk2, scan_in, update, capture, scan_out;
  logic [N-1:0] rd_data;
  logic [N-1:0] par_in = '0, sr_m = '0, sr_s = '0, scan_reg = '0;
  logic [N-1:0] cur_wr = '0, exp_rd = '0;
  int           shift_idx = 0, n_c1 = 0, n_c2 = 0, n_upd = 0, n_done = 0;
  int           n_cmp = 0, n_err = 0;
  int           cyc;
  logic [N-1:0] rd;

  always #5 clk = ~clk;

  scan_chain_driver #(.NUM_SCAN_BITS(N), .PW(PW), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .busy(busy), .clk1(clk1), .clk2(clk2),
    .scan_in(scan_in), .update(update), .capture(capture), .scan_out(scan_out)
  );

  // Two-phase chain: clk1 loads masters (par_in when capturing), clk2 moves masters into slaves.
  assign scan_out = sr_s[N-1];
  always @(posedge clk1) begin
    sr_m <= capture ? par_in : {sr_s[N-2:0], scan_in};
    n_c1++;
    if (!capture) begin
      chk("scan_in_bit", 32'(scan_in), 32'(cur_wr[3'(N - 1 - shift_idx)]));
      shift_idx++;
    end
  end
  always @(posedge clk2) begin
    sr_s <= sr_m;
    n_c2++;
  end
  always @(posedge update) begin
    scan_reg <= sr_s;
    n_upd++;
  end
  always @(posedge done) n_done++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outs", 32'({clk1, clk2, scan_in, update, capture, done, busy}), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_rd", 32'(rd_data), 0);
    end else begin
      chk("no_overlap", 32'(clk1 & clk2), 0);
      chk("busy_inv", 32'(busy), 32'(!cmd_ready));
      if (cmd_ready) begin
        chk("idle_outs", 32'({clk1, clk2, scan_in, update, capture, done}), 0);
        chk("idle_rd", 32'(rd_data), 32'(exp_rd));
      end
    end
  end

  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 5000) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [N-1:0] wr, input logic [N-1:0] par,
                       output int c, output logic [N-1:0] r);
    logic [N-1:0] exp_r, reg_before;
    int           exp_c;
    @(negedge clk);
    chk("ready_before", 32'(cmd_ready), 1);
    cmd_op = op; wr_data = wr; par_in = par; cmd_valid = 1'b1;
    n_c1 = 0; n_c2 = 0; n_upd = 0; cur_wr = wr; shift_idx = 0;
    exp_r      = op[0] ? par : sr_s;
    reg_before = scan_reg;
    exp_c = (op[0] ? 1 + 2 * PW + 2 * GAP : 0) + N * (S + 2 * PW + 2 * GAP) + (op[1] ? PW + GAP : 0) + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(c);
    chk("done_cycle", c, exp_c);
    chk("rd_data", 32'(rd_data), 32'(exp_r));
    r = rd_data;
    exp_rd = exp_r;
    chk("clk1_pulses", n_c1, N + 32'(op[0]));
    chk("clk2_pulses", n_c2, N + 32'(op[0]));
    chk("upd_pulses", n_upd, 32'(op[1]));
    chk("scan_reg", 32'(scan_reg), 32'(op[1] ? wr : reg_before));
    @(negedge clk);
    chk("ready_after", 32'(cmd_ready), 1);
  endtask

  initial begin
    int ndone0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 1);
    chk("reset_rd", 32'(rd_data), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({cmd_ready, busy}), 32'b10);

    issue(2'b10, 8'hA5, 8'h00, cyc, rd);
    chk("write_cyc_lit", cyc, 43);
    chk("write_reg_lit", 32'(scan_reg), 32'hA5);
    chk("write_upd_lit", n_upd, 1);

    issue(2'b01, 8'h00, 8'h3C, cyc, rd);
    chk("read_cyc_lit", cyc, 46);
    chk("read_rd_lit", 32'(rd), 32'h3C);
    chk("read_reg_lit", 32'(scan_reg), 32'hA5);

    issue(2'b11, 8'h5A, 8'h81, cyc, rd);
    chk("xchg_cyc_lit", cyc, 48);
    chk("xchg_rd_lit", 32'(rd), 32'h81);
    chk("xchg_reg_lit", 32'(scan_reg), 32'h5A);

    // Back-to-back: cmd_valid stays high while the word changes during the first command.
    @(negedge clk);
    cmd_op = 2'b11; wr_data = 8'h5A; par_in = 8'h81; cmd_valid = 1'b1;
    cur_wr = 8'h5A; shift_idx = 0;
    @(negedge clk);
    cmd_op = 2'b10; wr_data = 8'hFF;
    wait_done(cyc);
    chk("b2b_first_cyc", cyc, 48);
    chk("b2b_first_rd", 32'(rd_data), 32'h81);
    chk("b2b_first_reg", 32'(scan_reg), 32'h5A);
    exp_rd = 8'h81;
    @(negedge clk);
    chk("b2b_ready", 32'(cmd_ready), 1);
    cur_wr = 8'hFF; shift_idx = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_taken", 32'(cmd_ready), 0);
    wait_done(cyc);
    chk("b2b_second_cyc", cyc, 43);
    chk("b2b_second_rd", 32'(rd_data), 32'h5A);
    chk("b2b_second_reg", 32'(scan_reg), 32'hFF);
    exp_rd = 8'h5A;
    @(negedge clk);

    // Reset during bit 3 of a write.
    @(negedge clk);
    cmd_op = 2'b10; wr_data = 8'h33; cmd_valid = 1'b1;
    cur_wr = 8'h33; shift_idx = 0; n_c2 = 0; ndone0 = n_done;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 200 && n_c2 < 4; k++) @(negedge clk);
    chk("reach_bit3", n_c2, 4);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    exp_rd = '0;
    #1;
    chk("async_outs", 32'({clk1, clk2, scan_in, update, capture, done, busy}), 0);
    chk("async_ready", 32'(cmd_ready), 1);
    chk("async_rd", 32'(rd_data), 0);
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", n_done, ndone0);
    rst_n = 1'b1;
    issue(2'b10, 8'h11, 8'h00, cyc, rd);
    chk("reissue_cyc_lit", cyc, 43);
    chk("reissue_reg_lit", 32'(scan_reg), 32'h11);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/scan_chain_driver.md
# scan_chain_driver

On-chip master for the two-phase scan chain in front of the Kyber test core. It turns one host command into the scan_chain pin sequence: optional capture, an N-bit exchange shift and an optional update. It generates the non-overlapping clk1/clk2 pulses, drives scan_in, update and capture, and collects scan_out into a parallel read word. It sits between the test host (or a UART/SPI bridge) and the scan_chain instance.

## Interface
Parameters:
- NUM_SCAN_BITS, 395, chain length N
- PW, 2, high time of clk1, clk2 and update pulses, in clk cycles (≥1)
- GAP, 1, low time after each pulse, in clk cycles (≥1); guarantees clk1/clk2 non-overlap

Ports:
- clk  in  1  single system clock; all outputs are registered on it
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  bit0 = capture first, bit1 = update after shift
- wr_data  in  N  word to shift in; the MSB is shifted first
- rd_data  out  N  word shifted out; the first bit sampled lands in rd_data[N-1]
- done  out  1  one-cycle pulse when the command completes
- busy  out  1  equals ~cmd_ready
- clk1, clk2  out  1  scan phase clocks
- scan_in  out  1  serial data to the chain
- update  out  1  copies the shift register to scan_reg
- capture  out  1  selects par_in load
- scan_out  in  1  serial data from the chain

## Operation
- Acceptance: a command is accepted on a clk edge where cmd_valid && cmd_ready. On acceptance the block latches cmd_op and wr_data and drops cmd_ready. cmd_valid while busy is ignored and is not queued.
- Reset values: clk1, clk2, scan_in, update, capture, done = 0; rd_data = 0; cmd_ready = 1.
- FSM states: IDLE, CAP_SU, CAP_C1, CAP_G1, CAP_C2, CAP_G2, SH_SU, SH_C1, SH_G1, SH_C2, SH_G2, UPD, UPD_G, DONE.
- Capture sequence (op[0] = 1, else skip to SH_SU):
  - capture = 1 from CAP_SU through CAP_G2.
  - CAP_SU lasts 1 cycle.
  - C1/C2 states each last PW cycles with clk1/clk2 high; G states each last GAP cycles.
- Shift, bit i = N-1 down to 0:
  - SH_SU lasts S cycles (S = 1). scan_in = wr_data[i] for the whole bit.
  - scan_out is sampled on the last SH_SU cycle into the rd shift register.
  - Then clk1 high for PW, low for GAP, clk2 high for PW, low for GAP.
  - A 9-bit bit counter runs from N-1 to 0. After bit 0, go to UPD if op[1] = 1, else to DONE.
- Update: update = 1 for PW cycles (UPD), then 0 for GAP cycles (UPD_G).
- DONE lasts 1 cycle:
  - done = 1 and rd_data is loaded from the rd shift register.
  - rd_data holds until the next DONE.
  - Go to IDLE: cmd_ready rises the next cycle.
- scan_in returns to 0 outside the shift states. clk1 and clk2 are never high in the same cycle.

## Timing
- Cycle 0 is the accept edge; the first phase cycle is cycle 1.
- Phase lengths:
  - C = 1 + 2·PW + 2·GAP if op[0], else 0.
  - Shift = N·(S + 2·PW + 2·GAP).
  - U = PW + GAP if op[1], else 0.
- done is high in cycle C + Shift + U + 1. cmd_ready is high one cycle later.
- Example: N = 8, PW = 1, GAP = 1, op = 11 gives done in cycle 5 + 40 + 2 + 1 = 48. The next command can be accepted at the edge ending cycle 49.
- rst_n low at any time:
  - All outputs go to their reset values immediately (asynchronous).
  - No done is issued and the command is lost.
  - Chain contents are undefined; the host must reissue the command.

## Configuration
- SCAN_OUT_SYNC_EN defined: a 2-flop synchronizer is inserted on scan_out, S = 3, and sampling uses the synchronized value on the last SH_SU cycle.
- SCAN_OUT_SYNC_EN undefined: scan_out is sampled directly and S = 1. All latency formulas apply with the chosen S.

## Structure
- Package scan_drv_pkg:
  - FSM state enum typedef.
  - Op-bit localparams OP_CAPTURE = 0, OP_UPDATE = 1.
  - Function computing the cycles per bit.
- One sub-module, scan_phase_timer: a down-counter loaded with PW, GAP or S. It issues an expire strobe to advance the FSM.

## Test plan
Run the bench with the existing scan_chain model, NUM_SCAN_BITS = 8, PW = 1, GAP = 1.
- Reset: assert rst_n = 0 → all outputs 0, cmd_ready = 1, rd_data = 0. Release → still idle.
- Write: op = 10, wr_data = 0xA5 → 8 clk1 and 8 clk2 pulses with no overlap, 1 update pulse, scan_reg = 0xA5, done in cycle 43.
- Read: op = 01, par_in = 0x3C → rd_data = 0x3C, done in cycle 46, no update pulse, scan_reg unchanged.
- Exchange: op = 11, par_in = 0x81, wr_data = 0x5A → rd_data = 0x81, scan_reg = 0x5A, done in cycle 48.
- Busy/back-to-back: cmd_valid held high with a second word 0xFF → second command ignored until cmd_ready. Then accepted: scan_reg = 0xFF, rd_data = 0x5A.
- Reset mid-shift at bit 3 → outputs 0 at once, no done. A reissued op = 10 with 0x11 gives scan_reg = 0x11.
